// File: rtl/y86_ctrl_pkg.sv
// Shared control definitions for the sequential Y86-64 core: sequencer states,
// stage indices, processor status codes and instruction codes.
package y86_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetGo,
    StFetWait,
    StDecGo,
    StDecWait,
    StExeGo,
    StExeWait,
    StMemGo,
    StMemWait,
    StWbGo,
    StWbWait,
    StPcuGo,
    StPcuWait,
    StHalted
  } ctrl_state_e;

  localparam int unsigned StgFet = 0;
  localparam int unsigned StgDec = 1;
  localparam int unsigned StgExe = 2;
  localparam int unsigned StgMem = 3;
  localparam int unsigned StgWb  = 4;
  localparam int unsigned StgPcu = 5;
  localparam int unsigned NumStages = 6;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;
  localparam logic [2:0] StatTmo = 3'd5;

  localparam logic [3:0] IcHalt   = 4'd0;
  localparam logic [3:0] IcNop    = 4'd1;
  localparam logic [3:0] IcRrmovq = 4'd2;
  localparam logic [3:0] IcIrmovq = 4'd3;
  localparam logic [3:0] IcRmmovq = 4'd4;
  localparam logic [3:0] IcMrmovq = 4'd5;
  localparam logic [3:0] IcOpq    = 4'd6;
  localparam logic [3:0] IcJxx    = 4'd7;
  localparam logic [3:0] IcCall   = 4'd8;
  localparam logic [3:0] IcRet    = 4'd9;
  localparam logic [3:0] IcPushq  = 4'd10;
  localparam logic [3:0] IcPopq   = 4'd11;

  function automatic logic state_busy(input ctrl_state_e s);
    return !(s inside {StIdle, StHalted});
  endfunction

endpackage

// File: rtl/y86_stage_watchdog.sv
// Per-stage watchdog: cleared on each stage launch, counts wait cycles and flags
// the wait cycle in which the TIMEOUT_CYCLES limit is reached (0 disables it).
module y86_stage_watchdog
  import y86_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMR_W          = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam bit               WdOn  = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W:0]   Limit = (TMR_W + 1)'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] r_cnt;
  logic [TMR_W:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + {{TMR_W{1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= w_cnt_inc[TMR_W-1:0];
    end
  end

  // Expires during the wait cycle that would bring the count up to the limit.
  assign o_expired = WdOn && i_en && (w_cnt_inc == Limit);

endmodule

// File: rtl/y86_seq_stage_ctrl.sv
// Stage sequencer for the sequential Y86-64 core: launches each stage in order,
// waits for its done, owns wb/pc write strobes and status. Y86_PERF_CNT_EN adds counters.
module y86_seq_stage_ctrl
  import y86_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMR_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [5:0]  i_stage_done,
  input  logic [3:0]  i_icode,
  input  logic        i_instr_valid,
  input  logic        i_imem_err,
  input  logic        i_dmem_err,
  output logic [5:0]  o_stage_go,
  output logic        o_wb_we,
  output logic        o_pc_we,
  output logic        o_busy,
  output logic [2:0]  o_stat,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instr_cnt
);

  ctrl_state_e r_state, w_state_d;
  logic [2:0]  r_stat, w_stat_d;
  logic [5:0]  w_go;
  logic        w_wb_we, w_pc_we;
  logic        w_wd_clr, w_wd_en, w_wd_expired;
  logic        w_done_sel;
  logic        w_busy;

  y86_stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_comb begin
    w_state_d  = r_state;
    w_stat_d   = r_stat;
    w_go       = '0;
    w_wb_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_wd_clr   = 1'b0;
    w_wd_en    = 1'b0;
    w_done_sel = 1'b0;
    unique case (r_state)
      StIdle, StHalted: begin
        if (i_start) begin
          w_state_d = StFetGo;
          w_stat_d  = StatAok;
        end
      end
      StFetGo: begin
        w_go[StgFet] = 1'b1;
        w_wd_clr     = 1'b1;
        w_state_d    = StFetWait;
      end
      StFetWait: begin
        w_wd_en    = 1'b1;
        w_done_sel = i_stage_done[StgFet];
        if (w_done_sel) begin
          if (i_imem_err) begin
            w_state_d = StHalted;
            w_stat_d  = StatAdr;
          end else if (!i_instr_valid) begin
            w_state_d = StHalted;
            w_stat_d  = StatIns;
          end else if (i_icode == IcHalt) begin
            w_state_d = StHalted;
            w_stat_d  = StatHlt;
          end else begin
            w_state_d = StDecGo;
          end
        end
      end
      StDecGo: begin
        w_go[StgDec] = 1'b1;
        w_wd_clr     = 1'b1;
        w_state_d    = StDecWait;
      end
      StDecWait: begin
        w_wd_en    = 1'b1;
        w_done_sel = i_stage_done[StgDec];
        if (w_done_sel) w_state_d = StExeGo;
      end
      StExeGo: begin
        w_go[StgExe] = 1'b1;
        w_wd_clr     = 1'b1;
        w_state_d    = StExeWait;
      end
      StExeWait: begin
        w_wd_en    = 1'b1;
        w_done_sel = i_stage_done[StgExe];
        if (w_done_sel) w_state_d = StMemGo;
      end
      StMemGo: begin
        w_go[StgMem] = 1'b1;
        w_wd_clr     = 1'b1;
        w_state_d    = StMemWait;
      end
      StMemWait: begin
        w_wd_en    = 1'b1;
        w_done_sel = i_stage_done[StgMem];
        if (w_done_sel) begin
          if (i_dmem_err) begin
            w_state_d = StHalted;
            w_stat_d  = StatAdr;
          end else begin
            w_state_d = StWbGo;
          end
        end
      end
      StWbGo: begin
        w_go[StgWb] = 1'b1;
        w_wb_we     = 1'b1;
        w_wd_clr    = 1'b1;
        w_state_d   = StWbWait;
      end
      StWbWait: begin
        w_wd_en    = 1'b1;
        w_done_sel = i_stage_done[StgWb];
        if (w_done_sel) w_state_d = StPcuGo;
      end
      StPcuGo: begin
        w_go[StgPcu] = 1'b1;
        w_pc_we      = 1'b1;
        w_wd_clr     = 1'b1;
        w_state_d    = StPcuWait;
      end
      StPcuWait: begin
        w_wd_en    = 1'b1;
        w_done_sel = i_stage_done[StgPcu];
        if (w_done_sel) w_state_d = StFetGo;
      end
      default: w_state_d = StIdle;
    endcase
    // A done arriving on the expiry cycle takes precedence over the timeout.
    if (w_wd_en && !w_done_sel && w_wd_expired) begin
      w_state_d = StHalted;
      w_stat_d  = StatTmo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_stat  <= StatAok;
    end else begin
      r_state <= w_state_d;
      r_stat  <= w_stat_d;
    end
  end

  assign w_busy = state_busy(r_state);

  // Strobes are masked while reset is asserted so an aborted stage never fires.
  assign o_stage_go = w_go & {6{i_rst_n}};
  assign o_wb_we    = w_wb_we & i_rst_n;
  assign o_pc_we    = w_pc_we & i_rst_n;
  assign o_busy     = w_busy;
  assign o_stat     = r_stat;

`ifdef Y86_PERF_CNT_EN
  logic        w_launch, w_retire;
  logic [31:0] r_cycle_cnt, r_instr_cnt;

  assign w_launch = (r_state inside {StIdle, StHalted}) && i_start;
  assign w_retire = (r_state == StPcuWait) && i_stage_done[StgPcu];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else if (w_launch) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (w_busy)   r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;
`else
  assign o_cycle_cnt = 32'd0;
  assign o_instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_y86_seq_stage_ctrl.sv
// Self-checking bench for y86_seq_stage_ctrl: directed scenarios followed by random
// instructions, checked cycle by cycle against a stage-schedule model.
module tb_y86_seq_stage_ctrl;
  import y86_ctrl_pkg::*;

  localparam int Tmo = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [5:0]  i_stage_done;
  logic [3:0]  i_icode;
  logic        i_instr_valid;
  logic        i_imem_err;
  logic        i_dmem_err;
  logic [5:0]  o_stage_go;
  logic        o_wb_we;
  logic        o_pc_we;
  logic        o_busy;
  logic [2:0]  o_stat;
  logic [31:0] o_cycle_cnt;
  logic [31:0] o_instr_cnt;

  always #5 i_clk = ~i_clk;

  y86_seq_stage_ctrl #(
    .TIMEOUT_CYCLES (Tmo),
    .TMR_W          (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_stage_done  (i_stage_done),
    .i_icode       (i_icode),
    .i_instr_valid (i_instr_valid),
    .i_imem_err    (i_imem_err),
    .i_dmem_err    (i_dmem_err),
    .o_stage_go    (o_stage_go),
    .o_wb_we       (o_wb_we),
    .o_pc_we       (o_pc_we),
    .o_busy        (o_busy),
    .o_stat        (o_stat),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_instr_cnt   (o_instr_cnt)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         m_cycles;
  int         m_instr;
  bit         m_halted;
  logic [2:0] m_stat;
  int         lat [6];
  bit         rst_at_wb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_counters();
`ifdef Y86_PERF_CNT_EN
    check("cycle_cnt", o_cycle_cnt, 32'(m_cycles));
    check("instr_cnt", o_instr_cnt, 32'(m_instr));
`else
    check("cycle_cnt_tied", o_cycle_cnt, 32'd0);
    check("instr_cnt_tied", o_instr_cnt, 32'd0);
`endif
  endtask

  // One clock: check this cycle's outputs, then drive this cycle's inputs.
  task automatic step(input logic [5:0] done, input logic st, input logic [5:0] ego,
                      input logic ewb, input logic epc, input logic ebusy,
                      input logic [2:0] estat);
    @(posedge i_clk);
    #1;
    check("stage_go", 32'(o_stage_go), 32'(ego));
    check("wb_we", 32'(o_wb_we), 32'(ewb));
    check("pc_we", 32'(o_pc_we), 32'(epc));
    check("busy", 32'(o_busy), 32'(ebusy));
    check("stat", 32'(o_stat), 32'(estat));
    check_counters();
    i_stage_done = done;
    i_start      = st;
    if (ebusy) m_cycles++;
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d, input int e,
                         input int f);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d; lat[4] = e; lat[5] = f;
  endtask

  // Runs one instruction; lat[k] is the wait cycle (1-based) in which stage k reports
  // done, anything above Tmo meaning never.
  task automatic run_instr(input logic [3:0] ic, input logic iv, input logic ie,
                           input logic de);
    logic [2:0] code;
    logic [5:0] noise;
    int         w;
    int         nw;
    if (m_halted) begin
      step(6'($urandom), 1'b1, 6'b0, 1'b0, 1'b0, 1'b0, m_stat);
      m_halted = 1'b0;
      m_stat   = StatAok;
      m_cycles = 0;
      m_instr  = 0;
    end
    code = 3'd0;
    for (int k = 0; k < 6; k++) begin
      noise    = 6'($urandom);
      noise[k] = 1'($urandom_range(0, 1));
      step(noise, 1'($urandom), 6'(1 << k), k == 4, k == 5, 1'b1, StatAok);
      if (k == 0) begin
        i_icode       = ic;
        i_instr_valid = iv;
        i_imem_err    = ie;
        i_dmem_err    = de;
      end
      if (rst_at_wb && k == 4) begin
        i_rst_n = 1'b0;
        #1;
        check("rst_cycle_go", 32'(o_stage_go), 32'd0);
        check("rst_cycle_wb", 32'(o_wb_we), 32'd0);
        m_cycles = 0;
        m_instr  = 0;
        step(6'b0, 1'b0, 6'b0, 1'b0, 1'b0, 1'b0, StatAok);
        i_rst_n   = 1'b1;
        rst_at_wb = 1'b0;
        m_halted  = 1'b1;
        m_stat    = StatAok;
        return;
      end
      w  = lat[k];
      nw = (w > Tmo) ? Tmo : w;
      for (int j = 1; j <= nw; j++) begin
        noise    = 6'($urandom);
        noise[k] = (j == w);
        step(noise, 1'($urandom), 6'b0, 1'b0, 1'b0, 1'b1, StatAok);
      end
      if (w > Tmo) begin
        code = StatTmo;
        break;
      end
      if (k == 0) begin
        if (ie) code = StatAdr;
        else if (!iv) code = StatIns;
        else if (ic == IcHalt) code = StatHlt;
      end
      if (k == 3 && de) code = StatAdr;
      if (k == 5) m_instr++;
      if (code != 3'd0) break;
    end
    if (code != 3'd0) begin
      m_halted = 1'b1;
      m_stat   = code;
    end
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_start       = 1'b0;
    i_stage_done  = '0;
    i_icode       = IcNop;
    i_instr_valid = 1'b1;
    i_imem_err    = 1'b0;
    i_dmem_err    = 1'b0;
    m_cycles      = 0;
    m_instr       = 0;
    m_halted      = 1'b1;
    m_stat        = StatAok;
    rst_at_wb     = 1'b0;

    repeat (3) @(posedge i_clk);
    #1;
    check("reset_go", 32'(o_stage_go), 32'd0);
    check("reset_wb", 32'(o_wb_we), 32'd0);
    check("reset_pc", 32'(o_pc_we), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_stat", 32'(o_stat), 32'(StatAok));
    check_counters();
    i_rst_n = 1'b1;

    set_lat(1, 1, 1, 1, 1, 1);
    run_instr(IcIrmovq, 1'b1, 1'b0, 1'b0);
    run_instr(IcHalt, 1'b1, 1'b0, 1'b0);
    run_instr(IcNop, 1'b1, 1'b0, 1'b0);
    run_instr(IcMrmovq, 1'b1, 1'b0, 1'b1);
    run_instr(IcOpq, 1'b0, 1'b1, 1'b0);
    run_instr(IcOpq, 1'b0, 1'b0, 1'b0);
    set_lat(1, 1, Tmo + 1, 1, 1, 1);
    run_instr(IcRrmovq, 1'b1, 1'b0, 1'b0);
    set_lat(1, 1, Tmo, 1, 1, 1);
    run_instr(IcRrmovq, 1'b1, 1'b0, 1'b0);
    set_lat(2, 3, 2, 3, 2, 3);
    run_instr(IcCall, 1'b1, 1'b0, 1'b0);
    set_lat(1, 1, 1, 1, 1, 1);
    rst_at_wb = 1'b1;
    run_instr(IcRmmovq, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < 6; k++) begin
        lat[k] = ($urandom_range(0, 24) == 0) ? Tmo + 1 : int'($urandom_range(1, Tmo));
      end
      rst_at_wb = ($urandom_range(0, 29) == 0);
      run_instr(($urandom_range(0, 9) == 0) ? IcHalt : 4'($urandom_range(1, 11)),
                $urandom_range(0, 11) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 11) == 0);
    end

    if (m_halted) step(6'b0, 1'b0, 6'b0, 1'b0, 1'b0, 1'b0, m_stat);
    else step(6'b0, 1'b0, 6'b000001, 1'b0, 1'b0, 1'b1, StatAok);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
